// File: rtl/ppu_pkg.sv
// Shared fetch-state encoding and default raster timing for the PPU background fetch path.
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_SLEEP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_NT     = 3'd2,
    ST_AT     = 3'd3,
    ST_BG_LSB = 3'd4,
    ST_BG_MSB = 3'd5,
    ST_VBLANK = 3'd6
  } fetch_state_e;

  localparam int DEF_LINE_CLKS     = 1600;
  localparam int DEF_TOTAL_ROWS    = 262;
  localparam int DEF_VISIBLE_ROWS  = 240;
  localparam int DEF_VBLANK_ROW    = 241;
  localparam int DEF_FETCH_START_X = 127;
  localparam int DEF_SLOT_CLKS     = 8;
  localparam int DEF_SLOT_PHASE    = 3;
  localparam int DEF_NUM_TILES     = 34;
  localparam int DEF_SKIP_CLKS     = 8;

endpackage

// File: rtl/ppu_timing_counter.sv
// Raster x/y counters and frame parity; ODD_FRAME_SKIP_EN shortens the odd-frame pre-render line.
// o_line_end is combinational from the counter registers and marks the last clock of the current line.
module ppu_timing_counter import ppu_pkg::*; #(
  parameter int LINE_CLKS  = DEF_LINE_CLKS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS,
  parameter int SKIP_CLKS  = DEF_SKIP_CLKS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_ppu_en,
  output logic [$clog2(LINE_CLKS)-1:0]  o_x_cnt,
  output logic [$clog2(TOTAL_ROWS)-1:0] o_y_cnt,
  output logic                          o_odd_frame,
  output logic                          o_line_end
);

  localparam int X_W = $clog2(LINE_CLKS);
  localparam int Y_W = $clog2(TOTAL_ROWS);
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_CLKS - 1);
  localparam logic [X_W-1:0] X_SKIP = X_W'(LINE_CLKS - 1 - SKIP_CLKS);
  localparam logic [Y_W-1:0] Y_PRE  = Y_W'(TOTAL_ROWS - 1);
`ifdef ODD_FRAME_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_odd;
  logic           w_skip_hit;
  logic           w_line_end;

  // Early wrap only when rendering is on at the wrap point itself.
  assign w_skip_hit = (r_y == Y_PRE) && r_odd && i_ppu_en && (r_x == X_SKIP);
  assign w_line_end = (r_x == X_LAST) || (SKIP_EN && w_skip_hit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x   <= '0;
      r_y   <= Y_PRE;
      r_odd <= 1'b0;
    end else if (w_line_end) begin
      r_x <= '0;
      if (r_y == Y_PRE) begin
        r_y   <= '0;
        r_odd <= ~r_odd;
      end else begin
        r_y <= r_y + Y_W'(1);
      end
    end else begin
      r_x <= r_x + X_W'(1);
    end
  end

  assign o_x_cnt     = r_x;
  assign o_y_cnt     = r_y;
  assign o_odd_frame = r_odd;
  assign o_line_end  = w_line_end;

endmodule

// File: rtl/ppu_bg_fetch_sequencer.sv
// Background fetch FSM (NT/AT/LSB/MSB slots, two dummy NT fetches, vblank/nmi) over ppu_timing_counter.
// Optional ODD_FRAME_SKIP_EN shortens odd-frame pre-render lines; all outputs registered.
module ppu_bg_fetch_sequencer import ppu_pkg::*; #(
  parameter int LINE_CLKS     = DEF_LINE_CLKS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int VISIBLE_ROWS  = DEF_VISIBLE_ROWS,
  parameter int VBLANK_ROW    = DEF_VBLANK_ROW,
  parameter int FETCH_START_X = DEF_FETCH_START_X,
  parameter int SLOT_CLKS     = DEF_SLOT_CLKS,
  parameter int SLOT_PHASE    = DEF_SLOT_PHASE,
  parameter int NUM_TILES     = DEF_NUM_TILES,
  parameter int SKIP_CLKS     = DEF_SKIP_CLKS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ppu_en,
  input  logic                            nmi_en,
  output logic [$clog2(LINE_CLKS)-1:0]    x_cnt,
  output logic [$clog2(TOTAL_ROWS)-1:0]   y_cnt,
  output logic [2:0]                      fetch_state,
  output logic                            fetch_req,
  output logic [$clog2(NUM_TILES+2)-1:0]  tile_idx,
  output logic                            vblank,
  output logic                            odd_frame,
  output logic                            nmi
);

  localparam int X_W     = $clog2(LINE_CLKS);
  localparam int Y_W     = $clog2(TOTAL_ROWS);
  localparam int T_W     = $clog2(NUM_TILES + 2);
  localparam int SLOT_W  = $clog2(SLOT_CLKS);
  localparam int PRE_ROW = TOTAL_ROWS - 1;

  if ((FETCH_START_X + SLOT_CLKS * (4 * NUM_TILES + 3) + SKIP_CLKS >= LINE_CLKS) ||
      (VISIBLE_ROWS >= VBLANK_ROW) || (VBLANK_ROW >= PRE_ROW) ||
      (SLOT_CLKS < 2) || ((SLOT_CLKS & (SLOT_CLKS - 1)) != 0)) begin : g_bad_params
    $error("ppu_bg_fetch_sequencer: inconsistent timing parameters");
  end

  fetch_state_e   r_state;
  logic [T_W-1:0] r_tile;
  logic           r_dummy;
  logic           r_fetch_req;
  logic           r_vblank;
  logic           r_nmi;

  logic w_line_end;
  logic w_slot;
  logic w_vb_enter;
  logic w_vb_exit;
  logic w_fetch_row;
  logic w_last_tile;

  ppu_timing_counter #(
    .LINE_CLKS (LINE_CLKS),
    .TOTAL_ROWS(TOTAL_ROWS),
    .SKIP_CLKS (SKIP_CLKS)
  ) u_timing (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ppu_en   (ppu_en),
    .o_x_cnt    (x_cnt),
    .o_y_cnt    (y_cnt),
    .o_odd_frame(odd_frame),
    .o_line_end (w_line_end)
  );

  assign w_slot      = (x_cnt[SLOT_W-1:0] == SLOT_W'(SLOT_PHASE));
  // Decided one clock early so the state flips together with y_cnt.
  assign w_vb_enter  = w_line_end && (y_cnt == Y_W'(VBLANK_ROW - 1));
  assign w_vb_exit   = w_line_end && (y_cnt == Y_W'(PRE_ROW - 1));
  assign w_fetch_row = (y_cnt < Y_W'(VISIBLE_ROWS)) || (y_cnt == Y_W'(PRE_ROW));
  assign w_last_tile = (r_tile == T_W'(NUM_TILES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SLEEP;
      r_tile      <= '0;
      r_dummy     <= 1'b0;
      r_fetch_req <= 1'b0;
      r_vblank    <= 1'b0;
      r_nmi       <= 1'b0;
    end else begin
      r_fetch_req <= 1'b0;
      r_nmi       <= 1'b0;
      if (w_vb_enter) begin
        r_state  <= ST_VBLANK;
        r_vblank <= 1'b1;
        r_nmi    <= nmi_en;
        r_dummy  <= 1'b0;
      end else if (r_state == ST_SLEEP) begin
        if ((x_cnt == X_W'(FETCH_START_X)) && ppu_en && w_fetch_row)
          r_state <= ST_IDLE;
      end else if (r_state == ST_VBLANK) begin
        if (w_vb_exit) begin
          r_state  <= ST_SLEEP;
          r_vblank <= 1'b0;
          r_tile   <= '0;
        end
      end else if (!ppu_en) begin
        r_state <= ST_SLEEP;
        r_tile  <= '0;
        r_dummy <= 1'b0;
      end else if (w_slot) begin
        r_fetch_req <= 1'b1;
        case (r_state)
          ST_IDLE:   r_state <= ST_NT;
          ST_NT: begin
            // Once all tiles are done, NT repeats once more as the second dummy fetch.
            if (!w_last_tile) begin
              r_state <= ST_AT;
            end else if (!r_dummy) begin
              r_dummy <= 1'b1;
            end else begin
              r_state     <= ST_SLEEP;
              r_fetch_req <= 1'b0;
              r_tile      <= '0;
              r_dummy     <= 1'b0;
            end
          end
          ST_AT:     r_state <= ST_BG_LSB;
          ST_BG_LSB: r_state <= ST_BG_MSB;
          ST_BG_MSB: begin
            r_state <= ST_NT;
            r_tile  <= r_tile + T_W'(1);
          end
          default:   r_state <= ST_SLEEP;
        endcase
      end
    end
  end

  assign fetch_state = r_state;
  assign fetch_req   = r_fetch_req;
  assign tile_idx    = r_tile;
  assign vblank      = r_vblank;
  assign nmi         = r_nmi;

endmodule

// File: doc/ppu_bg_fetch_sequencer.md
PPU_BG_FETCH_SEQUENCER -- requirements
Module: ppu_bg_fetch_sequencer

Interface
REQ-001 Parameter LINE_CLKS, default 1600, clocks per scanline.
REQ-002 Parameter TOTAL_ROWS, default 262, scanlines per frame; pre-render row PRE_ROW = TOTAL_ROWS-1.
REQ-003 Parameter VISIBLE_ROWS, default 240, fetch rows 0..VISIBLE_ROWS-1.
REQ-004 Parameter VBLANK_ROW, default 241, first vblank row.
REQ-005 Parameter FETCH_START_X, default 127, x at which a line's fetch window opens.
REQ-006 Parameter SLOT_CLKS, default 8 (power of two), clocks per fetch slot; SLOT_PHASE, default 3, slot boundary phase.
REQ-007 Parameter NUM_TILES, default 34, NT/AT/LSB/MSB groups per line; SKIP_CLKS, default 8, odd-frame shortening.
REQ-008 clk  input  1  system clock, all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 ppu_en  input  1  rendering enable; gates fetching.
REQ-011 nmi_en  input  1  enables nmi pulse at vblank start.
REQ-012 x_cnt  output  X_W=$clog2(LINE_CLKS)  horizontal clock counter.
REQ-013 y_cnt  output  Y_W=$clog2(TOTAL_ROWS)  scanline counter.
REQ-014 fetch_state  output  3  current fetch state encoding.
REQ-015 fetch_req  output  1  one-cycle pulse on entry to NT, AT, BG_LSB or BG_MSB.
REQ-016 tile_idx  output  $clog2(NUM_TILES+2)  index of current fetch group, 0 at line start.
REQ-017 vblank, odd_frame  output  1 each  vblank flag, frame parity; nmi  output  1  one-cycle vblank-start pulse.

Function
REQ-018 x_cnt SHALL increment each clock, wrapping to 0 at line end (LINE_CLKS-1, or shortened per REQ-031).
REQ-019 y_cnt SHALL increment on x wrap; PRE_ROW wraps to 0; odd_frame SHALL toggle on that same wrap.
REQ-020 States: SLEEP=0, IDLE=1, NT=2, AT=3, BG_LSB=4, BG_MSB=5, VBLANK=6; registered, one-cycle transition latency.
REQ-021 SLEEP->IDLE when x_cnt==FETCH_START_X, ppu_en=1, and y_cnt<VISIBLE_ROWS or y_cnt==PRE_ROW.
REQ-022 IDLE->NT, NT->AT, AT->BG_LSB, BG_LSB->BG_MSB, BG_MSB->NT, each when x_cnt mod SLOT_CLKS == SLOT_PHASE.
REQ-023 After NUM_TILES BG_MSB slots, exactly two further NT slots (dummy fetches) SHALL follow, then SLEEP.
REQ-024 tile_idx SHALL increment on each BG_MSB->NT transition, clear on SLEEP entry.
REQ-025 ppu_en=0 in IDLE/NT/AT/BG_LSB/BG_MSB SHALL force SLEEP next cycle, no further fetch_req; re-enable takes effect only at the next FETCH_START_X.
REQ-026 Any state ->VBLANK on the cycle y_cnt becomes VBLANK_ROW, regardless of ppu_en; VBLANK->SLEEP when y_cnt becomes PRE_ROW.
REQ-027 vblank SHALL be 1 exactly while fetch_state==VBLANK.
REQ-028 nmi SHALL pulse one cycle on VBLANK entry iff nmi_en=1 that cycle.
REQ-029 Elaboration SHALL fail unless FETCH_START_X + SLOT_CLKS*(4*NUM_TILES+3) + SKIP_CLKS < LINE_CLKS and VISIBLE_ROWS < VBLANK_ROW < PRE_ROW.

Reset
REQ-030 rst SHALL set x_cnt=0, y_cnt=PRE_ROW, fetch_state=SLEEP, tile_idx=0, odd_frame=0, fetch_req=0, vblank=0, nmi=0, overriding everything, including mid-fetch.

Configuration
REQ-031 With ODD_FRAME_SKIP_EN defined: on PRE_ROW with odd_frame=1 and ppu_en=1 at the wrap cycle, line SHALL wrap at LINE_CLKS-1-SKIP_CLKS; fetch sequence unchanged. Without it: every line is LINE_CLKS clocks.

Structure
REQ-032 Package ppu_pkg SHALL hold the fetch state encoding and default timing constants.
REQ-033 Sub-module ppu_timing_counter SHALL own x_cnt, y_cnt, odd_frame and the skip logic; the FSM lives in the top.

Verification
REQ-034 Reset, ppu_en=1, defaults -> row 261: IDLE at x=128, NT at x=132, first fetch_req at x=132, SLEEP at x=1236 after 138 fetch_req pulses.
REQ-035 Row 10: fetch_req spacing exactly 8 clocks; tile_idx reaches 34 at last dummy NT.
REQ-036 nmi_en=1 -> vblank and nmi rise as y_cnt becomes 241; vblank falls as y_cnt becomes 261; nmi_en=0 -> no nmi.
REQ-037 ppu_en dropped at x=500 row 5 -> SLEEP at 501, no fetch_req until row 6 x=132.
REQ-038 ODD_FRAME_SKIP_EN, ppu_en=1 -> odd-frame row 261 ends at x=1591, even-frame at 1599; ppu_en=0 -> both 1599.
REQ-039 rst asserted mid-fetch row 100 -> all outputs at reset values next cycle.
